// File: rtl/multi_port_queueing_domain.sv
// multi_port_queueing_domain
//
// Queueing domain between the packetizer ports and the serializer. Each of NUM_PORTS input
// ports writes packets into one of NUM_QUEUES FIFOs, selected by the packet's queue id. An
// arbiter (round-robin, fixed priority, external grant, or hold) pops at most one packet per
// cycle into a registered valid/ready output stage. Per-queue occupancy hysteresis drives the
// kill_the_core throttle vector.
//
// Ports:
//   clock, reset             clock and synchronous active-high reset
//   in_packet/valid/qid      per-port packet, offer strobe and target queue
//   in_ready                 per-port accept strobe (combinational)
//   arb_mode                 0 round-robin, 1 fixed priority, 2 external grant, 3 hold
//   ext_id, ext_valid        external grant from the Scheduler
//   ext_ack                  registered; an external-grant pop happened last cycle
//   kill_high, kill_low      per-queue assert / release thresholds
//   kill_the_core            registered per-queue throttle request
//   occupancy, empty, full   per-queue status
//   out_packet/qid/valid     registered output stage
//   out_ready                serializer accepts out_packet
module multi_port_queueing_domain #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned NUM_QUEUES  = 4,
  parameter int unsigned DATA_SIZE   = 678,
  parameter int unsigned QUEUE_DEPTH = 16,
  localparam int unsigned QW = $clog2(NUM_QUEUES),
  localparam int unsigned OW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] in_packet,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS*QW-1:0]        in_qid,
  output logic [NUM_PORTS-1:0]           in_ready,
  input  logic [1:0]                     arb_mode,
  input  logic [QW-1:0]                  ext_id,
  input  logic                           ext_valid,
  output logic                           ext_ack,
  input  logic [NUM_QUEUES*OW-1:0]       kill_high,
  input  logic [NUM_QUEUES*OW-1:0]       kill_low,
  output logic [NUM_QUEUES-1:0]          kill_the_core,
  output logic [NUM_QUEUES*OW-1:0]       occupancy,
  output logic [NUM_QUEUES-1:0]          empty,
  output logic [NUM_QUEUES-1:0]          full,
  output logic [DATA_SIZE-1:0]           out_packet,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [QW-1:0]                  out_qid
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);

  localparam logic [1:0] ModeRr   = 2'd0;
  localparam logic [1:0] ModeFp   = 2'd1;
  localparam logic [1:0] ModeExt  = 2'd2;

  // FIFO storage and bookkeeping
  logic [DATA_SIZE-1:0] mem_q    [NUM_QUEUES][QUEUE_DEPTH];
  logic [PW-1:0]        wr_ptr_q [NUM_QUEUES];
  logic [PW-1:0]        rd_ptr_q [NUM_QUEUES];
  logic [OW-1:0]        occ_q    [NUM_QUEUES];
  logic [OW-1:0]        occ_d    [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] kill_q, kill_d;
  logic [NUM_QUEUES-1:0] q_empty, q_full;

  // Input side
  logic [QW-1:0]         port_qid [NUM_PORTS];
  logic [NUM_PORTS-1:0]  port_blocked;
  logic [NUM_QUEUES-1:0] push;
  logic [DATA_SIZE-1:0]  push_data [NUM_QUEUES];

  // Arbiter and output stage
  logic [QW-1:0]         rr_q;
  logic [QW-1:0]         rr_idx;
  logic                  sel_valid;
  logic [QW-1:0]         sel_id;
  logic                  stage_free;
  logic                  pop_en;
  logic [NUM_QUEUES-1:0] pop_vec;
  logic [DATA_SIZE-1:0]  out_packet_q;
  logic [QW-1:0]         out_qid_q;
  logic                  out_valid_q;
  logic                  ext_ack_q;

  // Status
  always_comb begin
    occupancy = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      q_empty[q]             = (occ_q[q] == '0);
      q_full[q]              = (occ_q[q] == OW'(QUEUE_DEPTH));
      occupancy[q*OW +: OW]  = occ_q[q];
    end
  end

  assign empty = q_empty;
  assign full  = q_full;

  // Input acceptance: a port loses to any lower-index valid port aimed at the same queue, even
  // if that port is itself refused, so at most one write lands per queue per cycle.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_qid[p]     = in_qid[p*QW +: QW];
      port_blocked[p] = 1'b0;
      for (int lp = 0; lp < p; lp++) begin
        if (in_valid[lp] && (in_qid[lp*QW +: QW] == in_qid[p*QW +: QW])) begin
          port_blocked[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    push     = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      push_data[q] = '0;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      // full is the pre-pop status: no bypass into a queue that is popping this cycle
      if (in_valid[p] && !q_full[port_qid[p]] && !port_blocked[p]) begin
        in_ready[p]            = 1'b1;
        push[port_qid[p]]      = 1'b1;
        push_data[port_qid[p]] = in_packet[p*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Arbitration
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    rr_idx    = '0;
    case (arb_mode)
      ModeRr: begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
          rr_idx = rr_q + QW'(i);
          if (!sel_valid && !q_empty[rr_idx]) begin
            sel_valid = 1'b1;
            sel_id    = rr_idx;
          end
        end
      end
      ModeFp: begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
          if (!sel_valid && !q_empty[i]) begin
            sel_valid = 1'b1;
            sel_id    = QW'(i);
          end
        end
      end
      ModeExt: begin
        // A grant to an empty queue is simply ignored.
        if (ext_valid && !q_empty[ext_id]) begin
          sel_valid = 1'b1;
          sel_id    = ext_id;
        end
      end
      default: begin
        sel_valid = 1'b0;
      end
    endcase
  end

  assign stage_free = !out_valid_q || out_ready;
  assign pop_en     = stage_free && sel_valid;

  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      pop_vec[q] = pop_en && (sel_id == QW'(q));
    end
  end

  // Next occupancy and kill hysteresis on the post-update count
  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      occ_d[q]  = occ_q[q] + OW'(push[q]) - OW'(pop_vec[q]);
      kill_d[q] = kill_q[q];
      if (kill_high[q*OW +: OW] == '0) begin
        kill_d[q] = 1'b1;
      end else if (occ_d[q] >= kill_high[q*OW +: OW]) begin
        kill_d[q] = 1'b1;
      end else if (occ_d[q] <= kill_low[q*OW +: OW]) begin
        kill_d[q] = 1'b0;
      end
    end
  end

  // Packet storage is not reset; the pointers define what is live.
  always_ff @(posedge clock) begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (push[q]) begin
        mem_q[q][wr_ptr_q[q]] <= push_data[q];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        occ_q[q]    <= '0;
      end
      kill_q <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (push[q]) begin
          wr_ptr_q[q] <= wr_ptr_q[q] + PW'(1);
        end
        if (pop_vec[q]) begin
          rd_ptr_q[q] <= rd_ptr_q[q] + PW'(1);
        end
        occ_q[q] <= occ_d[q];
      end
      kill_q <= kill_d;
    end
  end

  // Output stage and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      out_packet_q <= '0;
      out_qid_q    <= '0;
      out_valid_q  <= 1'b0;
      ext_ack_q    <= 1'b0;
      rr_q         <= '0;
    end else begin
      ext_ack_q <= pop_en && (arb_mode == ModeExt);
      if (pop_en) begin
        out_packet_q <= mem_q[sel_id][rd_ptr_q[sel_id]];
        out_qid_q    <= sel_id;
        out_valid_q  <= 1'b1;
      end else if (stage_free) begin
        out_valid_q  <= 1'b0;
      end
      if (pop_en && (arb_mode == ModeRr)) begin
        rr_q <= sel_id + QW'(1);
      end
    end
  end

  assign out_packet    = out_packet_q;
  assign out_qid       = out_qid_q;
  assign out_valid     = out_valid_q;
  assign ext_ack       = ext_ack_q;
  assign kill_the_core = kill_q;

endmodule
